// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter (and its RX successor).
//   parity_t         : parity mode selector
//   STOP_*           : stop_bits encodings (2 and 3 both mean two stop bits)
//   uart_tx_state_t  : transmitter FSM states
//   parity_bit()     : parity bit from mode and running XOR of sent data bits
package uart_pkg;

    typedef enum logic [2:0] {
        NO_PARITY    = 3'd0,
        EVEN_PARITY  = 3'd1,
        ODD_PARITY   = 3'd2,
        MARK_PARITY  = 3'd3,
        SPACE_PARITY = 3'd4
    } parity_t;

    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_1P5 = 2'd1;
    localparam logic [1:0] STOP_2   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5,
        ST_MAB    = 3'd6
    } uart_tx_state_t;

    // acc is the XOR of every data bit actually transmitted
    function automatic logic parity_bit(input parity_t mode, input logic acc);
        case (mode)
            EVEN_PARITY: return acc;
            ODD_PARITY:  return ~acc;
            MARK_PARITY: return 1'b1;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// Character handshake between the TX FIFO/register side and the transmitter.
//   tx_data  : character, LSB first
//   tx_valid : character available
//   tx_ready : character accepted when tx_valid & tx_ready
interface uart_tx_gen_if #(
    parameter int unsigned DATA_W = 9
) ();
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter.
//   div       : divisor; a full period is div+1 cycles
//   load      : load counter (div, or half-period when load_half)
//   load_half : with load, load ((div+1)>>1)-1 for a half-period; caller
//               must not request it when that term is zero
//   tick      : counter is zero (last cycle of the current period)
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic             load_half,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W:0]   div_p1;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] load_val;

    // div+1 is computed one bit wider so div = all-ones does not wrap
    assign div_p1   = {1'b0, div} + (DIV_W+1)'(1);
    assign half     = DIV_W'(div_p1 >> 1);
    assign load_val = load_half ? (half - DIV_W'(1)) : div;
    assign tick     = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter with programmable frame format, zero-gap
// back-to-back frames, line break and frame-done pulse.
//   clk, reset_n : clock, async active-low reset
//   enable       : allow new frames to be accepted
//   baud_div     : bit period = baud_div+1 clk
//   data_bits    : data bits per frame, clamped to 5..DATA_W
//   parity       : parity mode
//   stop_bits    : 0 = 1, 1 = 1.5, 2/3 = 2 stop bits
//   break_req    : hold line low while high (between frames)
//   tx_if        : character handshake (slave side)
//   tx_out       : serial line, idle high
//   tx_busy      : not idle
//   tx_done      : one-cycle pulse after each frame's final stop cycle
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_W = 9,
    parameter  int unsigned DIV_W  = 16,
    localparam int unsigned NB_W   = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [NB_W-1:0]  data_bits,
    input  parity_t          parity,
    input  logic [1:0]       stop_bits,
    input  logic             break_req,
    uart_tx_gen_if.slave     tx_if,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done
);

    uart_tx_state_t    state_q, state_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_busy_q;
    logic              armed_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [NB_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              par_acc_q, par_acc_d;
    logic              stop_ph_q, stop_ph_d;

    // frame configuration captured at handshake
    logic [DIV_W-1:0]  div_q;
    logic [NB_W-1:0]   nbits_q;
    parity_t           par_q;
    logic [1:0]        stop_q;

    logic [NB_W-1:0]   nb_clamp;
    logic [DIV_W-1:0]  tmr_div;
    logic              tmr_load, tmr_half, tick;
    logic              stop_ext, final_stop, tx_ready_c, hs;
    logic              acc_n;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .div       (tmr_div),
        .load      (tmr_load),
        .load_half (tmr_half),
        .tick      (tick)
    );

    // Clamp requested character length into the supported range
    always_comb begin
        if (data_bits < NB_W'(5)) begin
            nb_clamp = NB_W'(5);
        end else if (data_bits > NB_W'(DATA_W)) begin
            nb_clamp = NB_W'(DATA_W);
        end else begin
            nb_clamp = data_bits;
        end
    end

    // Stop phase 0 is followed by a second phase for 2 stop bits, or for 1.5
    // stop bits when the half term (div+1)>>1 is non-zero (div != 0)
    assign stop_ext   = !stop_ph_q &&
                        (((stop_q == STOP_1P5) && (div_q != '0)) || (stop_q >= STOP_2));
    assign final_stop = (state_q == ST_STOP) && tick && !stop_ext;
    assign tx_ready_c = armed_q && enable && !break_req &&
                        ((state_q == ST_IDLE) || final_stop);
    assign hs         = tx_if.tx_valid && tx_ready_c;
    assign acc_n      = par_acc_q ^ shift_q[0];

    assign tx_if.tx_ready = tx_ready_c;
    assign tx_out         = tx_out_q;
    assign tx_busy        = tx_busy_q;
    assign tx_done        = tx_done_q;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        tx_out_d  = tx_out_q;
        tx_done_d = 1'b0;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_acc_d = par_acc_q;
        stop_ph_d = stop_ph_q;
        tmr_load  = 1'b0;
        tmr_half  = 1'b0;
        tmr_div   = div_q;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && break_req) begin
                    state_d  = ST_BREAK;
                    tx_out_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d  = ST_DATA;
                    tx_out_d = shift_q[0];
                    tmr_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    par_acc_d = acc_n;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + NB_W'(1);
                    tmr_load  = 1'b1;
                    if (bit_cnt_q == (nbits_q - NB_W'(1))) begin
                        if (par_q == NO_PARITY) begin
                            state_d   = ST_STOP;
                            tx_out_d  = 1'b1;
                            stop_ph_d = 1'b0;
                        end else begin
                            state_d  = ST_PARITY;
                            tx_out_d = parity_bit(par_q, acc_n);
                        end
                    end else begin
                        tx_out_d = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    tx_out_d  = 1'b1;
                    stop_ph_d = 1'b0;
                    tmr_load  = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_ext) begin
                        stop_ph_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_half  = (stop_q == STOP_1P5);
                    end else begin
                        tx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                        tx_out_d  = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (!break_req) begin
                    state_d  = ST_MAB;
                    tx_out_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_div  = baud_div;
                end
            end
            ST_MAB: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_out_d = 1'b1;
            end
        endcase

        // Accepted character starts a frame from IDLE or the final stop cycle
        if (hs) begin
            state_d   = ST_START;
            tx_out_d  = 1'b0;
            tmr_load  = 1'b1;
            tmr_half  = 1'b0;
            tmr_div   = baud_div;
            shift_d   = tx_if.tx_data;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
            stop_ph_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tx_out_q  <= 1'b1;
            tx_done_q <= 1'b0;
            tx_busy_q <= 1'b0;
            armed_q   <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_acc_q <= 1'b0;
            stop_ph_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_out_q  <= tx_out_d;
            tx_done_q <= tx_done_d;
            tx_busy_q <= (state_d != ST_IDLE);
            armed_q   <= 1'b1;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_acc_q <= par_acc_d;
            stop_ph_q <= stop_ph_d;
        end
    end

    // Frame configuration capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            nbits_q <= NB_W'(5);
            par_q   <= NO_PARITY;
            stop_q  <= STOP_1;
        end else if (hs) begin
            div_q   <= baud_div;
            nbits_q <= nb_clamp;
            par_q   <= parity;
            stop_q  <= stop_bits;
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
module tb_uart_tx_gen;
    import uart_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] baud_div;
    logic [3:0]  data_bits;
    parity_t     parity;
    logic [1:0]  stop_bits;
    logic        break_req;
    logic        tx_out;
    logic        tx_busy;
    logic        tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_gen_if #(.DATA_W(9)) tx_if ();

    uart_tx_gen #(.DATA_W(9), .DIV_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .baud_div  (baud_div),
        .data_bits (data_bits),
        .parity    (parity),
        .stop_bits (stop_bits),
        .break_req (break_req),
        .tx_if     (tx_if),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a character in IDLE and complete the handshake; returns at start cycle 0
    task automatic send(input string tag, input logic [8:0] d);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        chk1({tag, " ready"}, tx_if.tx_ready, 1'b1);
        step();
        tx_if.tx_valid = 1'b0;
        chk1({tag, " busy"}, tx_busy, 1'b1);
    endtask

    // Check tx_out level per cycle for nb bits of per cycles each (bit 0 first)
    task automatic run_frame(input string tag, input logic [15:0] bits, input int nb,
                             input int per, output int rdy_cnt, output int rdy_at);
        rdy_cnt = 0;
        rdy_at  = -1;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < per; c++) begin
                chk1($sformatf("%s bit%0d cyc%0d", tag, i, c), tx_out, bits[i]);
                if (tx_if.tx_ready) begin
                    rdy_cnt++;
                    rdy_at = i * per + c;
                end
                step();
            end
        end
    endtask

    task automatic end_frame(input string tag);
        chk1({tag, " done"}, tx_done, 1'b1);
        chk1({tag, " idle line"}, tx_out, 1'b1);
        chk1({tag, " not busy"}, tx_busy, 1'b0);
        step();
        chk1({tag, " done clear"}, tx_done, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (tx_busy && n < 1000) begin
            step();
            n++;
        end
        chk1({tag, " reached idle"}, tx_busy, 1'b0);
    endtask

    // Stop-line high time seen before the next start edge with tx_valid held
    task automatic measure_stop(input int div, input logic [1:0] sb, input int exp);
        int cnt;
        string tag;
        tag = $sformatf("stop div%0d sb%0d", div, sb);
        baud_div       = 16'(div);
        stop_bits      = sb;
        tx_if.tx_data  = 9'h000;
        tx_if.tx_valid = 1'b1;
        chk1({tag, " ready"}, tx_if.tx_ready, 1'b1);
        step();
        repeat (9 * (div + 1)) step();
        cnt = 0;
        while (tx_out === 1'b1 && cnt < 200) begin
            cnt++;
            step();
        end
        chki({tag, " high time"}, cnt, exp);
        tx_if.tx_valid = 1'b0;
        wait_idle(tag);
    endtask

    parity_t par_modes [4] = '{EVEN_PARITY, ODD_PARITY, MARK_PARITY, SPACE_PARITY};
    logic    par_exp   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int     rc, ra;
        time    t_done1;
        logic [15:0] fbits;

        reset_n        = 1'b0;
        enable         = 1'b1;
        baud_div       = 16'd3;
        data_bits      = 4'd8;
        parity         = NO_PARITY;
        stop_bits      = 2'd0;
        break_req      = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 9'h000;

        // Reset state and arming
        #12;
        chk1("reset tx_out", tx_out, 1'b1);
        chk1("reset tx_busy", tx_busy, 1'b0);
        chk1("reset tx_done", tx_done, 1'b0);
        chk1("reset tx_ready", tx_if.tx_ready, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk1("ready before armed", tx_if.tx_ready, 1'b0);
        step();
        chk1("ready after armed", tx_if.tx_ready, 1'b1);

        // 8N1 0xA5, 4 clk per bit, done at cycle 40
        send("8N1", 9'h0A5);
        run_frame("8N1", 16'({1'b1, 8'hA5, 1'b0}), 10, 4, rc, ra);
        chki("8N1 ready cycles", rc, 1);
        chki("8N1 ready position", ra, 39);
        end_frame("8N1");

        // 7-bit frames of 0x1D5 (low 7 bits 1,0,1,0,1,0,1) under each parity mode;
        // config inputs are disturbed mid-frame and must not matter
        data_bits = 4'd7;
        for (int m = 0; m < 4; m++) begin
            parity = par_modes[m];
            send($sformatf("7-bit par%0d", m), 9'h1D5);
            parity    = NO_PARITY;
            baud_div  = 16'd9;
            data_bits = 4'd8;
            stop_bits = 2'd2;
            run_frame($sformatf("7-bit par%0d", m), 16'({1'b1, par_exp[m], 7'h55, 1'b0}),
                      10, 4, rc, ra);
            end_frame($sformatf("7-bit par%0d", m));
            baud_div  = 16'd3;
            data_bits = 4'd7;
            stop_bits = 2'd0;
        end

        // data_bits below minimum clamps to 5; baud_div=0 gives 1 clk bits
        baud_div  = 16'd0;
        data_bits = 4'd2;
        parity    = EVEN_PARITY;
        send("clamp5", 9'h013);
        run_frame("clamp5", 16'({1'b1, 1'b1, 5'h13, 1'b0}), 8, 1, rc, ra);
        end_frame("clamp5");

        // data_bits above DATA_W clamps to 9
        data_bits = 4'd15;
        parity    = NO_PARITY;
        send("clamp9", 9'h1D5);
        fbits = 16'({1'b1, 9'h1D5, 1'b0});
        run_frame("clamp9", fbits, 11, 1, rc, ra);
        end_frame("clamp9");

        // Stop-bit lengths
        data_bits = 4'd8;
        measure_stop(7, 2'd1, 12);
        measure_stop(7, 2'd2, 16);
        measure_stop(7, 2'd0, 8);
        measure_stop(7, 2'd3, 16);
        measure_stop(0, 2'd1, 1);

        // Back-to-back 0x00 then 0xFF, baud_div=1, tx_valid held
        baud_div       = 16'd1;
        stop_bits      = 2'd0;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 9'h000;
        chk1("b2b ready idle", tx_if.tx_ready, 1'b1);
        step();
        tx_if.tx_data = 9'h0FF;
        run_frame("b2b f1", 16'({1'b1, 8'h00, 1'b0}), 10, 2, rc, ra);
        chki("b2b f1 ready cycles", rc, 1);
        chki("b2b f1 ready position", ra, 19);
        chk1("b2b done1", tx_done, 1'b1);
        chk1("b2b no gap start", tx_out, 1'b0);
        t_done1 = $time;
        tx_if.tx_valid = 1'b0;
        run_frame("b2b f2", 16'({1'b1, 8'hFF, 1'b0}), 10, 2, rc, ra);
        chki("b2b done spacing", int'($time - t_done1), 200);
        end_frame("b2b f2");

        // Reset during the third data bit of a 0x00 frame
        baud_div = 16'd3;
        send("rst frame", 9'h000);
        repeat (13) step();
        chk1("rst pre line", tx_out, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk1("rst line high", tx_out, 1'b1);
        chk1("rst busy", tx_busy, 1'b0);
        chk1("rst ready", tx_if.tx_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk1("rst release ready", tx_if.tx_ready, 1'b0);
        chk1("rst release line", tx_out, 1'b1);
        step();
        chk1("rst armed ready", tx_if.tx_ready, 1'b1);
        send("post rst", 9'h03C);
        run_frame("post rst", 16'({1'b1, 8'h3C, 1'b0}), 10, 4, rc, ra);
        end_frame("post rst");

        // enable low blocks new frames
        enable         = 1'b0;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 9'h055;
        #1;
        chk1("disabled ready", tx_if.tx_ready, 1'b0);
        step();
        chk1("disabled line", tx_out, 1'b1);
        chk1("disabled busy", tx_busy, 1'b0);
        tx_if.tx_valid = 1'b0;
        enable         = 1'b1;
        step();

        // Break from idle for 100 clk; break beats a simultaneous tx_valid
        break_req      = 1'b1;
        tx_if.tx_valid = 1'b1;
        #1;
        chk1("break beats valid", tx_if.tx_ready, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 0) tx_if.tx_valid = 1'b0;
            chk1($sformatf("break low %0d", i), tx_out, 1'b0);
            chk1($sformatf("break ready %0d", i), tx_if.tx_ready, 1'b0);
        end
        chk1("break busy", tx_busy, 1'b1);
        break_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1($sformatf("mab high %0d", i), tx_out, 1'b1);
            chk1($sformatf("mab ready %0d", i), tx_if.tx_ready, 1'b0);
            chk1($sformatf("mab busy %0d", i), tx_busy, 1'b1);
        end
        step();
        chk1("after mab ready", tx_if.tx_ready, 1'b1);
        chk1("after mab busy", tx_busy, 1'b0);

        // Break raised mid-frame waits for the frame to finish
        baud_div = 16'd1;
        send("brk mid", 9'h000);
        break_req = 1'b1;
        run_frame("brk mid", 16'({1'b1, 8'h00, 1'b0}), 10, 2, rc, ra);
        chki("brk mid ready cycles", rc, 0);
        chk1("brk mid done", tx_done, 1'b1);
        chk1("brk mid line after frame", tx_out, 1'b1);
        step();
        chk1("brk mid break starts", tx_out, 1'b0);
        break_req = 1'b0;
        step();
        chk1("brk mid mab0", tx_out, 1'b1);
        chk1("brk mid mab0 busy", tx_busy, 1'b1);
        step();
        chk1("brk mid mab1 busy", tx_busy, 1'b1);
        step();
        chk1("brk mid idle", tx_busy, 1'b0);
        chk1("brk mid idle ready", tx_if.tx_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
